kianv_mem_responder: RTL
========================

Name: kianv_mem_responder

Overview:
- Memory-side target for the core's physical memory request interface (valid/ready, 4-bit write strobe, 34-bit physical address, 32-bit data, access_fault).
- Serves a word-addressed on-chip RAM window with configurable wait states.
- Returns access_fault for unmapped or misaligned requests.
- Used as boot/scratch RAM and as the bench responder for MMU and core bring-up.

Parameters:
- MEM_WORDS, 1024: RAM depth in 32-bit words; power of two, at least 2.
- BASE_ADDR, 34'h0_8000_0000: physical byte base of the window; aligned to 4*MEM_WORDS.
- WAIT_STATES, 2: extra cycles between request acceptance and the response; range 0..15.

Ports:
- clk  input  1  system clock; all state on rising edge.
- resetn  input  1  asynchronous active-low reset.
- mem_valid  input  1  request pending; held high by initiator until it sees mem_ready.
- mem_ready  output  1  one-cycle response strobe.
- mem_wstrb  input  4  byte write enables; 0 = read.
- mem_addr  input  34  physical byte address.
- mem_wdata  input  32  write data, byte lanes per mem_wstrb.
- mem_rdata  output  32  read data, valid only while mem_ready=1.
- access_fault  output  1  response is a fault; valid only while mem_ready=1.

Behaviour:
- Reset (asynchronous, resetn=0): state=IDLE, mem_ready=0, access_fault=0, mem_rdata=0, wait counter=0. RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE, mem_valid=1: latch mem_addr, mem_wstrb and mem_wdata into request registers. Compute hit = (addr >= BASE_ADDR) && (addr < BASE_ADDR + 4*MEM_WORDS) && (addr[1:0] == 0). Use 34-bit compares with no overflow wrap.
  - WAIT_STATES = 0: go to RESP.
  - Otherwise: load counter = WAIT_STATES-1 and go to WAIT.
- WAIT: counter decrements each cycle. At counter = 0, go to RESP.
  - mem_valid falls during WAIT (protocol abort): return to IDLE, no RAM write, no response.
- RAM index = (addr - BASE_ADDR) >> 2, truncated to log2(MEM_WORDS) bits.
- Outputs are registered on the edge entering RESP:
  - Read hit: mem_rdata = RAM[index], access_fault=0.
  - Write hit: mem_rdata = 0, access_fault=0. Each byte lane i with wstrb[i]=1 is written on that same edge; other lanes are untouched.
  - Miss (read or write): mem_rdata = 0, access_fault=1, RAM unchanged.
- RESP: mem_ready=1 for exactly one cycle, then IDLE. mem_ready, access_fault and mem_rdata return to 0 on the following edge.
- Latency: mem_valid first seen high at IDLE cycle t gives mem_ready high in cycle t+WAIT_STATES+1.
- Back-to-back: mem_valid still high in the cycle after RESP is accepted as a new request; the initiator guarantees it is new. Minimum issue period is WAIT_STATES+2 cycles.
- Request registers are held from acceptance to RESP; input changes during WAIT other than mem_valid are ignored.
- Address bits [33:32] non-zero with BASE_ADDR < 2^32 give a miss, i.e. a fault.
- Read-after-write to the same word on consecutive requests returns the new data.
- Reset asserted mid-WAIT or mid-RESP: immediate IDLE, outputs 0. A write not yet committed is lost; a write already committed remains in the RAM.

Test Plan:
- WAIT_STATES=2; write addr 0x0_8000_0010, wstrb 4'hF, wdata 0xDEADBEEF; then read the same address -> each mem_ready arrives 3 cycles after valid; read returns 0xDEADBEEF with access_fault=0.
- Partial write wstrb 4'b0101, wdata 0x11223344 over 0xDEADBEEF; read back -> 0xDE22BE44.
- Read 0x0_8000_1000 (one past a 1024-word window), read 0x0_8000_0002 (misaligned), and write 0x1_8000_0000 -> each gives mem_ready with access_fault=1 and mem_rdata=0; a later read of 0x0_8000_0000 shows the RAM unchanged.
- WAIT_STATES=0; back-to-back reads of 0x0_8000_0000 and 0x0_8000_0004 with valid held high -> ready pulses in cycles 1 and 3, correct data, never two consecutive ready cycles.
- Drop mem_valid during WAIT of a write to 0x0_8000_0020 -> no mem_ready, RAM word unchanged, FSM in IDLE next cycle.
- Assert resetn=0 during WAIT -> mem_ready, access_fault and mem_rdata are 0 asynchronously; after release, the next request completes normally.

Source files
------------

// File: rtl/kianv_mem_responder.sv
// kianv_mem_responder
//   Memory-side target for the core's physical request interface. Serves a
//   word-addressed on-chip RAM window [BASE_ADDR, BASE_ADDR + 4*MEM_WORDS)
//   with WAIT_STATES extra cycles of latency. Unmapped or misaligned
//   requests complete with access_fault.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for mem_valid; request captured on acceptance
//   WAIT    | counting wait states; mem_valid dropping aborts the access
//   RESP    | mem_ready (and data/fault) presented for exactly one cycle
//
// Ports
//   clk          system clock, rising edge
//   resetn       asynchronous active-low reset
//   mem_valid    request pending (held until mem_ready)
//   mem_ready    one-cycle response strobe
//   mem_wstrb    byte write enables, 0 = read
//   mem_addr     34-bit physical byte address
//   mem_wdata    write data
//   mem_rdata    read data, valid with mem_ready
//   access_fault response is a fault, valid with mem_ready
module kianv_mem_responder #(
   parameter int          MEM_WORDS   = 1024,
   parameter logic [33:0] BASE_ADDR   = 34'h0_8000_0000,
   parameter int          WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [3:0]  mem_wstrb,
   input  logic [33:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        access_fault
);

   localparam int IDX_W = $clog2(MEM_WORDS);
   // One bit wider than the address so the window end never wraps.
   localparam logic [34:0] BASE_EXT  = {1'b0, BASE_ADDR};
   localparam logic [34:0] LIMIT_EXT = BASE_EXT + 35'(4 * MEM_WORDS);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [33:0] addr_q, addr_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [31:0] wdata_q, wdata_d;
   logic        ready_q, ready_d;
   logic        fault_q, fault_d;
   logic [31:0] rdata_q, rdata_d;

   logic [31:0] ram [MEM_WORDS];

   // The access being completed: straight from the bus when responding
   // directly out of IDLE (no wait states), otherwise the captured request.
   logic [33:0]      cur_addr;
   logic [3:0]       cur_wstrb;
   logic [31:0]      cur_wdata;
   logic             cur_hit;
   logic [IDX_W-1:0] cur_idx;
   logic             commit;
   logic             ram_we;

   always_comb begin
      if (state_q == ST_IDLE) begin
         cur_addr  = mem_addr;
         cur_wstrb = mem_wstrb;
         cur_wdata = mem_wdata;
      end else begin
         cur_addr  = addr_q;
         cur_wstrb = wstrb_q;
         cur_wdata = wdata_q;
      end
      cur_hit = ({1'b0, cur_addr} >= BASE_EXT) &&
                ({1'b0, cur_addr} <  LIMIT_EXT) &&
                (cur_addr[1:0] == 2'b00);
      cur_idx = IDX_W'((cur_addr - BASE_ADDR) >> 2);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wstrb_d = wstrb_q;
      wdata_d = wdata_q;
      ready_d = 1'b0;
      fault_d = 1'b0;
      rdata_d = 32'h0;
      commit  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (mem_valid) begin
               addr_d  = mem_addr;
               wstrb_d = mem_wstrb;
               wdata_d = mem_wdata;
               if (WAIT_STATES == 0) begin
                  commit = 1'b1;
               end else begin
                  cnt_d   = 4'(WAIT_STATES - 1);
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            // Abort wins over completion: the initiator withdrew the request.
            if (!mem_valid) begin
               state_d = ST_IDLE;
            end else if (cnt_q == 4'd0) begin
               commit = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (commit) begin
         state_d = ST_RESP;
         ready_d = 1'b1;
         fault_d = !cur_hit;
         if (cur_hit && (cur_wstrb == 4'h0)) begin
            rdata_d = ram[cur_idx];
         end
      end

      ram_we = commit && cur_hit && (cur_wstrb != 4'h0);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= 34'h0;
         wstrb_q <= 4'h0;
         wdata_q <= 32'h0;
         ready_q <= 1'b0;
         fault_q <= 1'b0;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wstrb_q <= wstrb_d;
         wdata_q <= wdata_d;
         ready_q <= ready_d;
         fault_q <= fault_d;
         rdata_q <= rdata_d;
      end
   end

   // RAM contents survive reset; lanes are written on the edge entering RESP.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int i = 0; i < 4; i++) begin
            if (cur_wstrb[i]) begin
               ram[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
            end
         end
      end
   end

   assign mem_ready    = ready_q;
   assign access_fault = fault_q;
   assign mem_rdata    = rdata_q;

endmodule
